// File: rtl/core_pkg.sv
// Shared types and widths for the 9-bit core front end.
// Holds the fetch FSM encoding and the branch-offset sign extension.
package core_pkg;

    localparam int DEF_IW = 16;
    localparam int DEF_DW = 9;
    localparam int DEF_OW = 8;
    localparam int DEF_CW = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fetch_state_t;

    // Widened to 32 bits so callers truncate to their own PC width.
    function automatic logic [31:0] sext_off(
        input logic [DEF_OW-1:0] off
    );
        return {{(32-DEF_OW){off[DEF_OW-1]}}, off};
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Host, instruction-memory and decoder signals of the fetch sequencer.
// master drives requests and memory data; slave is the sequencer.
interface fetch_sequencer_if
    import core_pkg::*;
#(
    parameter int IW = DEF_IW,
    parameter int DW = DEF_DW,
    parameter int CW = DEF_CW
) ();

    logic              Start;
    logic [IW-1:0]     StartAddr;
    logic              Stall;
    logic              HaltReq;
    logic              BranchEn;
    logic              BranchRel;
    logic [DEF_OW-1:0] BranchOffset;
    logic [IW-1:0]     BranchTarget;
    logic [DW-1:0]     InstIn;
    logic [IW-1:0]     InstAddress;
    logic [DW-1:0]     InstOut;
    logic              InstValid;
    logic              Done;
    logic [CW-1:0]     CycleCnt;

    modport master (
        output Start, StartAddr, Stall, HaltReq,
        output BranchEn, BranchRel, BranchOffset,
        output BranchTarget, InstIn,
        input  InstAddress, InstOut, InstValid,
        input  Done, CycleCnt
    );

    modport slave (
        input  Start, StartAddr, Stall, HaltReq,
        input  BranchEn, BranchRel, BranchOffset,
        input  BranchTarget, InstIn,
        output InstAddress, InstOut, InstValid,
        output Done, CycleCnt
    );

endinterface

// File: rtl/pc_next.sv
// Combinational next-PC selector for the RUN state.
// Stall and halt both hold the PC; branches beat sequential step.
module pc_next
    import core_pkg::*;
#(
    parameter int IW = DEF_IW
) (
    input  logic [IW-1:0]     pc_i,
    input  logic              stall_i,
    input  logic              halt_i,
    input  logic              br_en_i,
    input  logic              br_rel_i,
    input  logic [DEF_OW-1:0] br_off_i,
    input  logic [IW-1:0]     br_tgt_i,
    output logic [IW-1:0]     pc_d_o
);

    logic [IW-1:0] rel_tgt;
    logic [IW-1:0] seq_tgt;

    assign rel_tgt = pc_i + IW'(sext_off(br_off_i));
    assign seq_tgt = pc_i + IW'(1);

    always_comb begin
        pc_d_o = seq_tgt;
        priority case (1'b1)
            stall_i:  pc_d_o = pc_i;
            halt_i:   pc_d_o = pc_i;
            br_en_i:  pc_d_o = br_rel_i ? rel_tgt : br_tgt_i;
            default:  pc_d_o = seq_tgt;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PC / fetch controller: Start-Done run handshake, branch/stall/halt,
// and a saturating RUN-cycle counter for benchmarking.
module fetch_sequencer
    import core_pkg::*;
#(
    parameter int IW = DEF_IW,
    parameter int CW = DEF_CW
) (
    input logic              CLK,
    input logic              Reset,
    fetch_sequencer_if.slave bus
);

    fetch_state_t  state_q, state_d;
    logic [IW-1:0] pc_q, pc_d, pc_step;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          start_q;
    logic          start_rise;
    logic          accept;
    logic          halt_take;

    assign start_rise = bus.Start & ~start_q;
    assign accept     = start_rise & (state_q != RUN);
    assign halt_take  = ~bus.Stall & bus.HaltReq;

    pc_next #(.IW(IW)) u_pc_next (
        .pc_i     (pc_q),
        .stall_i  (bus.Stall),
        .halt_i   (bus.HaltReq),
        .br_en_i  (bus.BranchEn),
        .br_rel_i (bus.BranchRel),
        .br_off_i (bus.BranchOffset),
        .br_tgt_i (bus.BranchTarget),
        .pc_d_o   (pc_step)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start_rise) state_d = RUN;
            RUN:        if (halt_take) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.InstAddress = pc_q;
        bus.InstOut     = bus.InstIn;
        bus.InstValid   = (state_q == RUN) & ~bus.Stall;
        bus.Done        = done_q;
        bus.CycleCnt    = cnt_q;
    end

    always_comb begin
        pc_d   = pc_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        if (accept) begin
            pc_d   = bus.StartAddr;
            cnt_d  = '0;
            done_d = 1'b0;
        end else if (state_q == RUN) begin
            pc_d   = pc_step;
            // Saturate so long runs never read back as short ones.
            cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
            if (halt_take) done_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            pc_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            start_q <= bus.Start;
        end
    end

endmodule
